sat_meas_collector: RTL and testbench
=====================================

# sat_meas_collector

Upstream feeder for the linear position solver. Accepts satellite measurements one at a time (ECEF x, y, z and pseudorange r, signed fixed-point), validates each record, and assembles four into a parallel bundle. It then launches the solver with a one-cycle start pulse and holds the bundle stable until the solver reports done or a timeout expires. It replaces ad-hoc loading of solver inputs and makes the measurement path synthesizable.

## Interface
- W, 40: width of every coordinate and range word; signed two's complement.
- FRAC, 8: fractional bits (metres × 2^FRAC); informational, no arithmetic depends on it.
- TIMEOUT, 1024: max cycles in WAIT before abort; must be ≥ 2.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream record present.
- in_ready  out  1  collector accepts the record this cycle.
- in_x, in_y, in_z  in  W  satellite ECEF position.
- in_r  in  W  pseudorange.
- flush  in  1  discard partial set and abort any pending solve.
- solver_done  in  1  solver completion pulse (level tolerated).
- sat_x, sat_y, sat_z, sat_r  out  4*W  bundle; slot k at bits [k*W +: W].
- solver_start  out  1  one-cycle launch pulse.
- count  out  3  records held (0..4).
- state  out  2  0=COLLECT, 1=LAUNCH, 2=WAIT.
- err_drop  out  1  one-cycle pulse: record rejected.
- err_timeout  out  1  one-cycle pulse: WAIT expired.

## Operation
- Reset: state=COLLECT, count=0, all bundle words 0, solver_start=0, err_*=0, timeout counter 0.
- in_ready = (state==COLLECT) && !flush.
- COLLECT: a handshake (in_valid && in_ready) with in_r > 0 writes the record to slot count, then count+1. If in_r ≤ 0 (signed), the record is consumed, not stored, and err_drop pulses next cycle; count is unchanged.
- When the 4th record is stored: state → LAUNCH.
- LAUNCH: solver_start=1 for exactly this cycle, then WAIT; timeout counter cleared.
- WAIT: bundle frozen. solver_done=1 → COLLECT with count=0. The bundle keeps its last values until overwritten slot by slot. Otherwise the counter increments; when it reaches TIMEOUT-1 without done → err_timeout pulse, COLLECT, count=0.
- solver_done outside WAIT is ignored.
- flush (any state) → COLLECT, count=0, no pulse; flush beats in_valid, solver_done and timeout in the same cycle.
- rst beats flush; reset mid-WAIT abandons the solve silently.
- Slot data is not cleared on a set boundary; only count governs validity.

## Timing
- Accept to stored: 1 cycle (registered).
- 4th accept at edge N: state=LAUNCH after N, solver_start high during cycle N+1, state=WAIT after N+1.
- Minimum set-to-set period: 4 accepts + LAUNCH + ≥1 WAIT cycle = 6 cycles.
- Done sampled in WAIT at edge M: in_ready high from cycle M+1.
- Timeout: err_timeout asserted exactly TIMEOUT cycles after entering WAIT.
- All outputs registered except in_ready (combinational from state and flush).

## Structure
- Package sat_pkg: W, FRAC, NSAT=4, state encoding constants, slot-select function.
- Sub-module sat_slot_bank: 4×(x,y,z,r) register file with write-enable and slot index, flattened read buses.
- Top: FSM, count, timeout counter, range check.

## Test plan
- Reset, then 4 records, r = 23204698, 21585835, 31364260, 24966798 m (×256), x1=2088202×256 → solver_start one cycle after 4th accept; sat_r slot 2 = 31364260×256; count=4; state=WAIT.
- 3rd record with r = 0, then r = −5 → two err_drop pulses, count stays 2; next valid record lands in slot 2.
- Full set, hold solver_done=0 with TIMEOUT=16 → err_timeout exactly 16 cycles after WAIT entry; in_ready high the following cycle.
- flush asserted with count=3 and in_valid=1 the same cycle → record not taken, count=0, no error pulse.
- solver_done pulsed during COLLECT with count=2 → ignored; solver_done in WAIT → count=0, bundle unchanged until the next write.
- rst asserted in WAIT → all outputs zero the next cycle; a subsequent 4-record set launches normally.

Source files
------------

// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared widths, state encoding and slot decode for the measurement collector
package sat_pkg;
  localparam int SAT_W    = 40;
  localparam int SAT_FRAC = 8;
  localparam int NSAT     = 4;
  localparam int SLOT_W   = $clog2(NSAT);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2
  } state_t;

  function automatic logic [NSAT-1:0] slot_sel(input logic [SLOT_W-1:0] idx);
    return NSAT'(1) << idx;
  endfunction
endpackage

// File: rtl/sat_slot_bank.sv
// rtl/sat_slot_bank.sv - four-slot (x,y,z,r) register file with flattened read buses
module sat_slot_bank
  import sat_pkg::*;
#(
  parameter int W = SAT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [SLOT_W-1:0] i_idx,
  input  logic [W-1:0]      i_x,
  input  logic [W-1:0]      i_y,
  input  logic [W-1:0]      i_z,
  input  logic [W-1:0]      i_r,
  output logic [NSAT*W-1:0] o_x,
  output logic [NSAT*W-1:0] o_y,
  output logic [NSAT*W-1:0] o_z,
  output logic [NSAT*W-1:0] o_r
);
  logic [W-1:0]    r_x [NSAT];
  logic [W-1:0]    r_y [NSAT];
  logic [W-1:0]    r_z [NSAT];
  logic [W-1:0]    r_r [NSAT];
  logic [NSAT-1:0] w_sel;

  assign w_sel = slot_sel(i_idx) & {NSAT{i_we}};

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NSAT; k++) begin
      if (i_rst) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
        r_z[k] <= '0;
        r_r[k] <= '0;
      end else if (w_sel[k]) begin
        r_x[k] <= i_x;
        r_y[k] <= i_y;
        r_z[k] <= i_z;
        r_r[k] <= i_r;
      end
    end
  end

  for (genvar k = 0; k < NSAT; k++) begin : g_out
    assign o_x[k*W +: W] = r_x[k];
    assign o_y[k*W +: W] = r_y[k];
    assign o_z[k*W +: W] = r_z[k];
    assign o_r[k*W +: W] = r_r[k];
  end
endmodule

// File: rtl/sat_meas_collector.sv
// rtl/sat_meas_collector.sv - validates measurement records, bundles four, launches the solver and
// supervises the solve with a timeout
module sat_meas_collector
  import sat_pkg::*;
#(
  parameter int W       = SAT_W,
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [W-1:0]      i_in_x,
  input  logic [W-1:0]      i_in_y,
  input  logic [W-1:0]      i_in_z,
  input  logic [W-1:0]      i_in_r,
  input  logic              i_flush,
  input  logic              i_solver_done,
  output logic [NSAT*W-1:0] o_sat_x,
  output logic [NSAT*W-1:0] o_sat_y,
  output logic [NSAT*W-1:0] o_sat_z,
  output logic [NSAT*W-1:0] o_sat_r,
  output logic              o_solver_start,
  output logic [2:0]        o_count,
  output logic [1:0]        o_state,
  output logic              o_err_drop,
  output logic              o_err_timeout
);
  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_count, w_count_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          r_start, w_start_nxt;
  logic          r_drop, w_drop_nxt;
  logic          r_tmo_err, w_tmo_err_nxt;
  logic          w_accept;
  logic          w_r_pos;
  logic          w_we;

  assign o_in_ready = (r_state == ST_COLLECT) && !i_flush;
  assign w_accept   = i_in_valid && o_in_ready;
  // Strictly positive range: sign bit clear and not all zeros.
  assign w_r_pos    = !i_in_r[W-1] && (|i_in_r);
  assign w_we       = w_accept && w_r_pos;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_COLLECT;
      r_count   <= '0;
      r_tmo     <= '0;
      r_start   <= 1'b0;
      r_drop    <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_tmo     <= w_tmo_nxt;
      r_start   <= w_start_nxt;
      r_drop    <= w_drop_nxt;
      r_tmo_err <= w_tmo_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_tmo_nxt     = r_tmo;
    w_start_nxt   = 1'b0;
    w_drop_nxt    = 1'b0;
    w_tmo_err_nxt = 1'b0;
    if (i_flush) begin
      w_state_nxt = ST_COLLECT;
      w_count_nxt = '0;
      w_tmo_nxt   = '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (w_r_pos) begin
              w_count_nxt = r_count + 3'd1;
              if (r_count == 3'(NSAT - 1)) begin
                w_state_nxt = ST_LAUNCH;
                w_start_nxt = 1'b1;
              end
            end else begin
              w_drop_nxt = 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          w_state_nxt = ST_WAIT;
          w_tmo_nxt   = '0;
        end
        ST_WAIT: begin
          // Done wins over a timeout landing in the same cycle.
          if (i_solver_done) begin
            w_state_nxt = ST_COLLECT;
            w_count_nxt = '0;
          end else if (r_tmo == TMO_LAST) begin
            w_state_nxt   = ST_COLLECT;
            w_count_nxt   = '0;
            w_tmo_err_nxt = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + TW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_COLLECT;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  sat_slot_bank #(.W(W)) u_bank (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_we  (w_we),
    .i_idx (r_count[SLOT_W-1:0]),
    .i_x   (i_in_x),
    .i_y   (i_in_y),
    .i_z   (i_in_z),
    .i_r   (i_in_r),
    .o_x   (o_sat_x),
    .o_y   (o_sat_y),
    .o_z   (o_sat_z),
    .o_r   (o_sat_r)
  );

  assign o_solver_start = r_start;
  assign o_count        = r_count;
  assign o_state        = r_state;
  assign o_err_drop     = r_drop;
  assign o_err_timeout  = r_tmo_err;
endmodule

// File: tb/tb_sat_meas_collector.sv
// tb/tb_sat_meas_collector.sv - scoreboard bench: stimulus queues expected pulses, a negedge monitor
// pops and compares kind and cycle
module tb_sat_meas_collector;
  localparam int W   = 40;
  localparam int TMO = 16;
  localparam int K_START = 0;
  localparam int K_DROP  = 1;
  localparam int K_TMO   = 2;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t q[$];

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, flush, done;
  logic [W-1:0] in_x, in_y, in_z, in_r;
  logic [4*W-1:0] sat_x, sat_y, sat_z, sat_r;
  logic         solver_start, err_drop, err_timeout;
  logic [2:0]   count;
  logic [1:0]   state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] xa [4];
  logic [W-1:0] ra [4];
  logic [W-1:0] m5;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sat_meas_collector #(.W(W), .TIMEOUT(TMO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_x        (in_x),
    .i_in_y        (in_y),
    .i_in_z        (in_z),
    .i_in_r        (in_r),
    .i_flush       (flush),
    .i_solver_done (done),
    .o_sat_x       (sat_x),
    .o_sat_y       (sat_y),
    .o_sat_z       (sat_z),
    .o_sat_r       (sat_r),
    .o_solver_start(solver_start),
    .o_count       (count),
    .o_state       (state),
    .o_err_drop    (err_drop),
    .o_err_timeout (err_timeout)
  );

  function automatic logic [W-1:0] slot(input logic [4*W-1:0] bus, input int k);
    return bus[k*W +: W];
  endfunction

  task automatic chk(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic expect_pulse(input int kind, input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected pulse at cyc=%0d", name, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        failures++;
        $display("FAIL %s actual kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                 name, kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (solver_start) expect_pulse(K_START, "solver_start");
    if (err_drop)     expect_pulse(K_DROP, "err_drop");
    if (err_timeout) begin
      expect_pulse(K_TMO, "err_timeout");
      chk("ready_at_timeout", in_ready, 1);
    end
  end

  // Called at a negedge; the record is accepted on the following posedge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] z, input logic [W-1:0] r);
    in_valid = 1'b1;
    in_x = x; in_y = y; in_z = z; in_r = r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    xa[0] = 40'd2088202 << 8; xa[1] = 40'd1000; xa[2] = 40'd2000; xa[3] = 40'd3000;
    ra[0] = 40'd23204698 << 8; ra[1] = 40'd21585835 << 8;
    ra[2] = 40'd31364260 << 8; ra[3] = 40'd24966798 << 8;
    m5 = -40'sd5;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; done = 1'b0;
    in_x = '0; in_y = '0; in_z = '0; in_r = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_state", state, 0);
    chk("rst_start", solver_start, 0);
    chk("rst_errs", {err_drop, err_timeout}, 0);
    chk("rst_sat_x", sat_x, 0);
    chk("rst_sat_r", sat_r, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      if (k == 3) push(K_START, cyc + 1);
      send(xa[k], 40'(k + 10), 40'(k + 20), ra[k]);
    end
    chk("a_state_launch", state, 1);
    chk("a_count", count, 4);
    @(negedge clk);
    chk("a_state_wait", state, 2);
    chk("a_sat_r2", slot(sat_r, 2), ra[2]);
    chk("a_sat_x0", slot(sat_x, 0), xa[0]);
    chk("a_ready_wait", in_ready, 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("done_state", state, 0);
    chk("done_count", count, 0);
    chk("done_sat_r2_kept", slot(sat_r, 2), ra[2]);
    chk("done_ready", in_ready, 1);

    send(40'd11, 40'd12, 40'd13, 40'd500);
    send(40'd21, 40'd22, 40'd23, 40'd600);
    push(K_DROP, cyc + 1);
    send(40'd31, 40'd32, 40'd33, 40'd0);
    push(K_DROP, cyc + 1);
    send(40'd41, 40'd42, 40'd43, m5);
    chk("drop_count", count, 2);
    send(40'd51, 40'd52, 40'd53, 40'd700);
    chk("after_drop_count", count, 3);
    chk("after_drop_x2", slot(sat_x, 2), 40'd51);
    chk("after_drop_r2", slot(sat_r, 2), 40'd700);

    in_valid = 1'b1; in_x = 40'd61; in_r = 40'd800; flush = 1'b1;
    #1;
    chk("flush_ready", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_state", state, 0);
    chk("flush_x3_kept", slot(sat_x, 3), xa[3]);

    send(40'd71, 40'd1, 40'd1, 40'd900);
    send(40'd72, 40'd1, 40'd1, 40'd901);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("done_ignored_count", count, 2);
    chk("done_ignored_state", state, 0);
    send(40'd73, 40'd1, 40'd1, 40'd902);
    push(K_START, cyc + 1);
    push(K_TMO, cyc + 2 + TMO);
    send(40'd74, 40'd1, 40'd1, 40'd903);
    @(negedge clk);
    chk("tmo_state_wait", state, 2);
    for (int i = 0; i < 40 && state != 2'd0; i++) @(negedge clk);
    chk("tmo_state", state, 0);
    chk("tmo_count", count, 0);
    chk("tmo_x3", slot(sat_x, 3), 40'd74);

    for (int k = 0; k < 4; k++) begin
      if (k == 3) push(K_START, cyc + 1);
      send(40'(k + 100), 40'(k + 200), 40'(k + 300), 40'(k + 400));
    end
    @(negedge clk);
    chk("pre_rst_state", state, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("wrst_count", count, 0);
    chk("wrst_state", state, 0);
    chk("wrst_pulses", {solver_start, err_drop, err_timeout}, 0);
    chk("wrst_bundle", sat_x | sat_y | sat_z | sat_r, 0);

    for (int k = 0; k < 4; k++) begin
      if (k == 3) push(K_START, cyc + 1);
      send(40'(k + 110), 40'(k + 210), 40'(k + 310), 40'(k + 410));
    end
    chk("relaunch_state", state, 1);
    @(negedge clk);
    chk("relaunch_wait", state, 2);
    chk("relaunch_y1", slot(sat_y, 1), 40'd211);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("relaunch_done_state", state, 0);
    repeat (TMO + 4) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
